cpu_decode: RTL and testbench

Second pipeline stage of the CPU. Consumes the 48-bit instruction and PC from fetch, captures them into the 2a pipeline register, and decodes fields. It reads the internal 16×32 register file, with a writeback bypass, and presents operands to execute. It generates `stall_2a` back to fetch for load-use hazards and for downstream back-pressure.

---
 rtl/cpu_decode.sv | 182 ++++++++++++++++++
 tb/tb_cpu_decode.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode.sv
// Decode stage: captures fetch output into the 2a register, reads operands from
// the 16x32 register file (with writeback bypass) and raises load-use stalls.
module cpu_decode #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [47:0] instruction_1a,
    input  logic [31:0] pc_1a,
    output logic        stall_2a,
    input  logic        stall_3a,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        valid_2a,
    output logic [7:0]  opcode_2a,
    output logic [3:0]  rd_2a,
    output logic [31:0] rs_val_2a,
    output logic [31:0] rt_val_2a,
    output logic [31:0] imm_2a,
    output logic [31:0] pc_2a,
    output logic        writes_rd_2a,
    output logic        illegal_2a
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_ADDI = 8'h03;
    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_ST   = 8'h11;

    logic        valid_q,   valid_d;
    logic [7:0]  opcode_q,  opcode_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  rd_q,      rd_d;
    logic [3:0]  rs_q,      rs_d;
    logic [31:0] imm_q,     imm_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] rf_q [NREGS];
    logic [31:0] rf_d [NREGS];

    logic [7:0]  op_1a;
    logic [3:0]  rd_1a;
    logic [3:0]  rs_1a;
    logic [3:0]  rt_1a;
    logic        op_1a_known;
    logic        hz;
    logic [3:0]  rs_idx;
    logic [3:0]  rt_idx;

    assign op_1a = instruction_1a[47:40];
    assign rd_1a = instruction_1a[39:36];
    assign rs_1a = instruction_1a[35:32];
    assign rt_1a = instruction_1a[3:0];

    assign op_1a_known = (op_1a == OP_NOP) || (op_1a == OP_ADD) || (op_1a == OP_SUB) ||
                         (op_1a == OP_ADDI) || (op_1a == OP_LD) || (op_1a == OP_ST);

    // Load-use: the LD in 2a produces rd_q only after memory, so any 1a reader must wait.
    always_comb begin
        hz = 1'b0;
        if (valid_q && (opcode_q == OP_LD) && (rd_q != 4'd0)) begin
            case (op_1a)
                OP_ADD, OP_SUB: hz = (rs_1a == rd_q) || (rt_1a == rd_q);
                OP_ADDI, OP_LD: hz = (rs_1a == rd_q);
                OP_ST:          hz = (rs_1a == rd_q) || (rd_1a == rd_q);
                default:        hz = 1'b0;
            endcase
        end
    end

    assign stall_2a = hz | stall_3a;

    // NOTE: every variable in always_comb starts from a default (here the held value),
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        if (stall_3a) begin
            // Execute is blocked: hold everything, even over a pending hazard.
        end else if (hz) begin
            valid_d   = 1'b0;
            opcode_d  = OP_NOP;
            illegal_d = 1'b0;
            rd_d      = 4'd0;
            rs_d      = 4'd0;
            imm_d     = 32'd0;
            pc_d      = 32'd0;
        end else begin
            valid_d   = (op_1a != OP_NOP);
            opcode_d  = op_1a_known ? op_1a : OP_NOP;
            illegal_d = !op_1a_known;
            rd_d      = rd_1a;
            rs_d      = rs_1a;
            imm_d     = instruction_1a[31:0];
            pc_d      = pc_1a - 32'd4;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_rd != 4'd0)) begin
            rf_d[wb_rd] = wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q   <= 1'b0;
            opcode_q  <= OP_NOP;
            illegal_q <= 1'b0;
            rd_q      <= 4'd0;
            rs_q      <= 4'd0;
            imm_q     <= 32'd0;
            pc_q      <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
        end
    end

    // NOTE: the register file must come out of reset as all zeros, so it is built
    // from resettable flops rather than an unreset RAM.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Unused operand ports select index 0, which always reads as zero.
    always_comb begin
        rs_idx = 4'd0;
        rt_idx = 4'd0;
        case (opcode_q)
            OP_ADD, OP_SUB: begin
                rs_idx = rs_q;
                rt_idx = imm_q[3:0];
            end
            OP_ADDI, OP_LD: rs_idx = rs_q;
            OP_ST: begin
                rs_idx = rs_q;
                rt_idx = rd_q;
            end
            default: begin
                rs_idx = 4'd0;
                rt_idx = 4'd0;
            end
        endcase
    end

    assign rs_val_2a = (rs_idx == 4'd0) ? 32'd0 :
                       (wb_en && (wb_rd == rs_idx)) ? wb_data : rf_q[rs_idx];
    assign rt_val_2a = (rt_idx == 4'd0) ? 32'd0 :
                       (wb_en && (wb_rd == rt_idx)) ? wb_data : rf_q[rt_idx];

    assign valid_2a     = valid_q;
    assign opcode_2a    = opcode_q;
    assign illegal_2a   = illegal_q;
    assign rd_2a        = rd_q;
    assign imm_2a       = imm_q;
    assign pc_2a        = pc_q;
    assign writes_rd_2a = ((opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                           (opcode_q == OP_ADDI) || (opcode_q == OP_LD)) && (rd_q != 4'd0);

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed literal checks plus randomized traffic compared
// every cycle against an instruction-level model of the decode stage.
module tb_cpu_decode;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [47:0] instruction_1a;
    logic [31:0] pc_1a;
    logic        stall_2a;
    logic        stall_3a;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid_2a;
    logic [7:0]  opcode_2a;
    logic [3:0]  rd_2a;
    logic [31:0] rs_val_2a;
    logic [31:0] rt_val_2a;
    logic [31:0] imm_2a;
    logic [31:0] pc_2a;
    logic        writes_rd_2a;
    logic        illegal_2a;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_decode dut (
        .clk(clk), .rst_b(rst_b),
        .instruction_1a(instruction_1a), .pc_1a(pc_1a),
        .stall_2a(stall_2a), .stall_3a(stall_3a),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .valid_2a(valid_2a), .opcode_2a(opcode_2a), .rd_2a(rd_2a),
        .rs_val_2a(rs_val_2a), .rt_val_2a(rt_val_2a), .imm_2a(imm_2a),
        .pc_2a(pc_2a), .writes_rd_2a(writes_rd_2a), .illegal_2a(illegal_2a)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction word sitting in 2a (zero for a bubble), its address,
    // and the architectural register file.
    logic [47:0] m_ir;
    logic [31:0] m_pc;
    logic [31:0] m_rf [16];

    function automatic bit is_known(input logic [7:0] op);
        return op == 8'h00 || op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h10 || op == 8'h11;
    endfunction

    function automatic logic [31:0] reg_value(input logic [3:0] r);
        if (r == 4'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit reads_reg(input logic [47:0] ir, input logic [3:0] r);
        case (ir[47:40])
            8'h01, 8'h02: return r == ir[35:32] || r == ir[3:0];
            8'h03, 8'h10: return r == ir[35:32];
            8'h11:        return r == ir[35:32] || r == ir[39:36];
            default:      return 1'b0;
        endcase
    endfunction

    function automatic bit model_hz();
        return m_ir[47:40] == 8'h10 && m_ir[39:36] != 4'd0 && reads_reg(instruction_1a, m_ir[39:36]);
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_ir = '0;
            m_pc = '0;
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
        end else begin
            if (!stall_3a) begin
                if (model_hz()) begin
                    m_ir = '0;
                    m_pc = '0;
                end else begin
                    m_ir = instruction_1a;
                    m_pc = pc_1a - 32'd4;
                end
            end
            if (wb_en && wb_rd != 4'd0) m_rf[wb_rd] = wb_data;
        end
    end

    // Single compare process: every falling edge, all outputs versus the model.
    always @(negedge clk) begin
        logic [7:0]  op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        op   = m_ir[47:40];
        e_rs = (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h10 || op == 8'h11)
               ? reg_value(m_ir[35:32]) : 32'd0;
        e_rt = (op == 8'h01 || op == 8'h02) ? reg_value(m_ir[3:0]) :
               (op == 8'h11) ? reg_value(m_ir[39:36]) : 32'd0;
        check("m_valid",   {63'd0, valid_2a},   {63'd0, op != 8'h00});
        check("m_opcode",  {56'd0, opcode_2a},  {56'd0, is_known(op) ? op : 8'h00});
        check("m_illegal", {63'd0, illegal_2a}, {63'd0, !is_known(op)});
        check("m_rd",      {60'd0, rd_2a},      {60'd0, m_ir[39:36]});
        check("m_imm",     {32'd0, imm_2a},     {32'd0, m_ir[31:0]});
        check("m_pc",      {32'd0, pc_2a},      {32'd0, m_pc});
        check("m_wr",      {63'd0, writes_rd_2a},
              {63'd0, (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h10) && m_ir[39:36] != 4'd0});
        check("m_rs_val",  {32'd0, rs_val_2a},  {32'd0, e_rs});
        check("m_rt_val",  {32'd0, rt_val_2a},  {32'd0, e_rt});
        check("m_stall",   {63'd0, stall_2a},   {63'd0, model_hz() || stall_3a});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        st;
        logic [7:0]  ops [7];
        rst_b = 1'b0;
        instruction_1a = '0;
        pc_1a = 32'h4;
        stall_3a = 1'b0;
        wb_en = 1'b0;
        wb_rd = '0;
        wb_data = '0;
        #12;
        check("rst_valid",  {63'd0, valid_2a}, 64'd0);
        check("rst_stall",  {63'd0, stall_2a}, 64'd0);
        check("rst_pc",     {32'd0, pc_2a},    64'd0);
        rst_b = 1'b1;
        tick();

        // ADD r1 = r2 + r3 fetched from 0x4
        instruction_1a = 48'h01_1_2_00000003;
        pc_1a = 32'h8;
        tick();
        check("add_valid", {63'd0, valid_2a},     64'd1);
        check("add_op",    {56'd0, opcode_2a},    64'h01);
        check("add_rd",    {60'd0, rd_2a},        64'd1);
        check("add_pc",    {32'd0, pc_2a},        64'h4);
        check("add_wr",    {63'd0, writes_rd_2a}, 64'd1);
        check("add_rs",    {32'd0, rs_val_2a},    64'd0);
        check("add_rt",    {32'd0, rt_val_2a},    64'd0);

        // Writeback r5, then ADDI r6 = r5 + 0x10
        wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'hDEADBEEF;
        instruction_1a = 48'h03_6_5_00000010;
        tick();
        wb_en = 1'b0;
        #1;
        check("addi_rs",  {32'd0, rs_val_2a}, 64'hDEADBEEF);
        check("addi_imm", {32'd0, imm_2a},    64'h10);

        // Same-cycle bypass on r8
        instruction_1a = 48'h03_6_8_00000010;
        tick();
        wb_en = 1'b1; wb_rd = 4'd8; wb_data = 32'hCAFEF00D;
        instruction_1a = 48'h00_0_0_00000000;
        #1;
        check("bypass_rs", {32'd0, rs_val_2a}, 64'hCAFEF00D);
        tick();
        wb_en = 1'b0;

        // LD r4 then dependent ADD r7 = r4 + r1
        instruction_1a = 48'h10_4_1_00000000;
        tick();
        instruction_1a = 48'h01_7_4_00000001;
        #1;
        check("ld_stall", {63'd0, stall_2a}, 64'd1);
        tick();
        check("ld_bubble_valid", {63'd0, valid_2a}, 64'd0);
        check("ld_bubble_op",    {56'd0, opcode_2a}, 64'd0);
        check("ld_bubble_stall", {63'd0, stall_2a}, 64'd0);
        tick();
        check("ld_dep_op", {56'd0, opcode_2a}, 64'h01);
        check("ld_dep_rd", {60'd0, rd_2a},     64'd7);

        // LD r0 never stalls
        instruction_1a = 48'h10_0_1_00000000;
        tick();
        instruction_1a = 48'h01_7_0_00000001;
        #1;
        check("ld0_stall", {63'd0, stall_2a}, 64'd0);
        tick();
        check("ld0_next_op", {56'd0, opcode_2a}, 64'h01);

        // Back-pressure for three cycles holds the ADD in 2a
        stall_3a = 1'b1;
        instruction_1a = 48'h03_2_1_00000055;
        #1;
        check("bp_stall0", {63'd0, stall_2a}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_op", {56'd0, opcode_2a}, 64'h01);
            check("bp_hold_rd", {60'd0, rd_2a},     64'd7);
            check("bp_stall",   {63'd0, stall_2a},  64'd1);
        end
        stall_3a = 1'b0;
        tick();
        check("bp_release_op",  {56'd0, opcode_2a}, 64'h03);
        check("bp_release_imm", {32'd0, imm_2a},    64'h55);

        // Illegal opcode with a write to r0 in the same cycle
        instruction_1a = 48'h7F_3_2_00000000;
        wb_en = 1'b1; wb_rd = 4'd0; wb_data = 32'hFFFFFFFF;
        tick();
        wb_en = 1'b0;
        #1;
        check("ill_flag",  {63'd0, illegal_2a},   64'd1);
        check("ill_op",    {56'd0, opcode_2a},    64'd0);
        check("ill_valid", {63'd0, valid_2a},     64'd1);
        check("ill_wr",    {63'd0, writes_rd_2a}, 64'd0);
        instruction_1a = 48'h01_9_0_00000000;
        tick();
        check("r0_rs", {32'd0, rs_val_2a}, 64'd0);
        check("r0_rt", {32'd0, rt_val_2a}, 64'd0);

        // PC wrap
        pc_1a = 32'h0;
        instruction_1a = 48'h01_1_2_00000003;
        tick();
        check("pc_wrap", {32'd0, pc_2a}, 64'hFFFFFFFC);
        pc_1a = 32'h100;

        // Reset in the middle of a load-use stall
        instruction_1a = 48'h10_4_1_00000000;
        tick();
        instruction_1a = 48'h01_7_4_00000001;
        #1;
        check("mid_hz_stall", {63'd0, stall_2a}, 64'd1);
        rst_b = 1'b0;
        #1;
        check("mid_rst_stall", {63'd0, stall_2a},  64'd0);
        check("mid_rst_valid", {63'd0, valid_2a},  64'd0);
        check("mid_rst_op",    {56'd0, opcode_2a}, 64'd0);
        check("mid_rst_pc",    {32'd0, pc_2a},     64'd0);
        instruction_1a = 48'h03_6_5_00000010;
        #1;
        rst_b = 1'b1;
        tick();
        check("rf_cleared", {32'd0, rs_val_2a}, 64'd0);

        // Randomized traffic; fetch holds its word while stall_2a is high
        ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h02; ops[3] = 8'h03;
        ops[4] = 8'h10; ops[5] = 8'h11; ops[6] = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st = stall_2a;
            tick();
            if (!st) begin
                logic [7:0] op;
                op = ops[$urandom_range(0, 6)];
                if ($urandom_range(0, 6) == 0) op = 8'($urandom);
                instruction_1a = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                                  28'($urandom), 4'($urandom_range(0, 7))};
                pc_1a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            end
            stall_3a = ($urandom_range(0, 3) == 0);
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_rd    = 4'($urandom_range(0, 15));
            wb_data  = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst_b = 1'b0;
                #2;
                rst_b = 1'b1;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
